oblivious_transfer_receiver: RTL and testbench
==============================================

// Module: oblivious_transfer_receiver
// PURPOSE
//  Receiver end of the 1-out-of-2 RSA oblivious transfer. Takes N, e, x0, x1 (16 B) over a byte stream,
//  blinds the chosen x_b with a local key k, and returns v = (x_b + k^e) mod N (4 B).
//  Then takes m0', m1' (8 B) and recovers m_b = (m_b' - k) mod N. Sits between the UART byte link and the host.
// PARAMETERS
//  W  32  operand width in bits; multiple of 8; byte count per word = W/8
// PORTS
//  clk           in   1  clock, all logic on rising edge
//  rstn          in   1  asynchronous, active-low reset
//  start         in   1  1-cycle pulse in IDLE: latch choice and k, begin session; ignored elsewhere
//  choice        in   1  selector b (0 -> message0, 1 -> message1), sampled on start
//  k             in   W  blinding key, sampled on start
//  rx_valid      in   1  incoming byte valid
//  rx_ready      out  1  block can accept a byte
//  rx_data       in   8  incoming byte
//  tx_valid      out  1  outgoing byte valid
//  tx_ready      in   1  link accepts outgoing byte
//  tx_data       out  8  outgoing byte
//  busy          out  1  high from start until DONE exits
//  result_valid  out  1  1-cycle pulse: result holds m_b
//  result        out  W  recovered message; held until next start
//  error         out  1  set when N<2; held until next start
// BEHAVIOUR
//  Reset (async, rstn=0): state IDLE; rx_ready, tx_valid, busy, result_valid, error = 0; tx_data, result = 0.
//    Reset mid-session aborts with no byte emitted after release.
//  Handshakes: rx byte taken when rx_valid&&rx_ready. tx byte taken when tx_valid&&tx_ready.
//    tx_valid/tx_data hold until taken. Words are little-endian: byte 0 is bits[7:0].
//  FSM:
//    IDLE: on start, latch b and k; clear error and result; busy=1; go RX_KEY.
//    RX_KEY: rx_ready=1; take 16 bytes in order N, e, x0, x1. After last byte, rx_ready=0.
//      If N<2: error=1, go DONE. Otherwise go RED.
//    RED: kr = k mod N, then xr = x_b mod N, each via MODMUL(a,1).
//    EXP: ke = kr^e mod N, left-to-right square-and-multiply.
//      Acc starts at 1; scan all W bits of e from MSB.
//      Per bit: acc=MODMUL(acc,acc); if bit=1, acc=MODMUL(acc,kr). e=0 gives ke=1.
//    SUM: v = xr+ke (W+1 bits); if v>=N, subtract N. 1 cycle.
//    TX_V: send v as 4 bytes. Next byte is presented the cycle after the previous is taken.
//    RX_MSG: rx_ready=1; take 8 bytes m0', m1'. Keep only m_b'; discard the other.
//    UNBLIND: t = m_b' mod N (MODMUL(m_b',1)). result = t>=kr ? t-kr : t-kr+N. 1 cycle after reduction.
//    DONE: result_valid=1 for 1 cycle (0 in the error case); busy=0; go IDLE.
//  MODMUL(a,b), b<N, any a: interleaved shift-add, W iterations, MSB of a first.
//    Per iteration: r=2r+a[i]*b in W+2 bits, then up to 2 conditional subtractions of N.
//    Exactly W cycles plus 1 setup cycle. Result < N.
//  Latency: EXP <= 2*W*(W+1) cycles; no dependence on link timing outside TX_V/RX_*.
//  Extra bytes arriving outside RX_* states are not accepted (rx_ready=0). start while busy is ignored.
//  All arithmetic unsigned modulo N; intermediates never exceed W+2 bits.
// TESTING
//  1. N=3233, e=17, x0=100, x1=200, k=5, b=1; rx A1 0C 00 00 11 00 00 00 64 00 00 00 C8 00 00 00
//     -> tx 35 00 00 00 (v=53).
//     Then rx 77 07 00 00 ED 03 00 00 -> result=1000, result_valid 1 cycle, error=0.
//  2. Same key, b=0, x0=3000 -> v=2853 (x+ke wraps past N).
//     Then m0'=2 -> result=3230 (unblind borrows N).
//  3. e=0, k=7, b=0, x0=10, N=3233 -> v=11.
//     Also k=3240 (>=N) -> kr=7; same v as k=7.
//  4. N=1 -> error=1, no tx bytes, result_valid stays 0, busy drops; next start clears error.
//  5. tx_ready low 20 cycles per byte and rx_valid gapped randomly -> identical bytes/result to test 1;
//     tx_data stable while tx_valid&&!tx_ready.
//  6. rstn low during EXP, then start -> no stray tx byte; rerun of test 1 passes.
//     start pulse while busy -> ignored.

Source files
------------

// File: rtl/oblivious_transfer_receiver.sv
// Receiver side of 1-out-of-2 RSA oblivious transfer: blinds x_b with k^e mod N,
// sends v over the byte link, then unblinds the chosen returned message.
module oblivious_transfer_receiver #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         start,
    input  logic         choice,
    input  logic [W-1:0] k,
    input  logic         rx_valid,
    output logic         rx_ready,
    input  logic [7:0]   rx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic [7:0]   tx_data,
    output logic         busy,
    output logic         result_valid,
    output logic [W-1:0] result,
    output logic         error
);
    localparam int NB = W / 8;

    typedef enum logic [3:0] {
        S_IDLE, S_RX_KEY, S_RED, S_EXP, S_SUM, S_TX_V, S_RX_MSG, S_UNBLIND, S_DONE
    } state_t;

    state_t       state;
    logic [1:0]   phase;
    logic         b_sel;
    logic [W-1:0] k_reg, n_reg, e_reg, xb, kr, xr, acc, mb, sr, tx_sr;
    logic [W-1:0] mm_a, mm_b;
    logic [W+1:0] mm_r;
    logic [15:0]  mm_cnt, bit_cnt;
    logic [7:0]   byte_cnt;
    logic [1:0]   word_cnt;
    logic         mm_run;

    // One interleaved shift-add step; 2r+a*b < 3N so two trial subtractions suffice.
    function automatic logic [W+1:0] mm_step(input logic [W+1:0] r, input logic a_bit,
                                             input logic [W-1:0] m, input logic [W-1:0] n);
        logic [W+1:0] t;
        logic [W+1:0] n2;
        n2 = {2'b00, n};
        t  = (r << 1) + (a_bit ? {2'b00, m} : '0);
        if (t >= n2) t = t - n2;
        if (t >= n2) t = t - n2;
        return t;
    endfunction

    function automatic logic [W-1:0] add_mod(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] n);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, n}) s = s - {1'b0, n};
        return s[W-1:0];
    endfunction

    // Operands are both < N, so the wrapped W-bit result of t-kr+N is exact.
    function automatic logic [W-1:0] sub_mod(input logic [W-1:0] t, input logic [W-1:0] b,
                                             input logic [W-1:0] n);
        return (t >= b) ? t - b : t - b + n;
    endfunction

    function automatic logic [W-1:0] shift_in(input logic [W-1:0] s, input logic [7:0] d);
        return W'({d, s} >> 8);
    endfunction

    logic         rx_fire, tx_fire, rx_last;
    logic [W-1:0] rx_word, v_sum;
    logic [W+1:0] mm_next;

    assign rx_fire = rx_valid && rx_ready;
    assign tx_fire = tx_valid && tx_ready;
    assign rx_last = rx_fire && (byte_cnt == 8'(NB - 1));
    assign rx_word = shift_in(sr, rx_data);
    assign v_sum   = add_mod(xr, acc, n_reg);
    assign mm_next = mm_step(mm_r, mm_a[W-1], mm_b, n_reg);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= S_IDLE;
            phase        <= 2'd0;
            mm_run       <= 1'b0;
            rx_ready     <= 1'b0;
            tx_valid     <= 1'b0;
            tx_data      <= 8'd0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
            error        <= 1'b0;
        end else begin
            if (mm_run) begin
                mm_r   <= mm_next;
                mm_a   <= mm_a << 1;
                mm_cnt <= mm_cnt - 16'd1;
                if (mm_cnt == 16'd1) mm_run <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    result_valid <= 1'b0;
                    if (start) begin
                        b_sel    <= choice;
                        k_reg    <= k;
                        error    <= 1'b0;
                        result   <= '0;
                        busy     <= 1'b1;
                        rx_ready <= 1'b1;
                        byte_cnt <= 8'd0;
                        word_cnt <= 2'd0;
                        state    <= S_RX_KEY;
                    end
                end
                S_RX_KEY: begin
                    if (rx_fire) begin
                        sr       <= rx_word;
                        byte_cnt <= byte_cnt + 8'd1;
                    end
                    if (rx_last) begin
                        byte_cnt <= 8'd0;
                        word_cnt <= word_cnt + 2'd1;
                        case (word_cnt)
                            2'd0: n_reg <= rx_word;
                            2'd1: e_reg <= rx_word;
                            2'd2: if (!b_sel) xb <= rx_word;
                            default: begin
                                if (b_sel) xb <= rx_word;
                                rx_ready <= 1'b0;
                                phase    <= 2'd0;
                                if (n_reg < W'(2)) begin
                                    error <= 1'b1;
                                    state <= S_DONE;
                                end else begin
                                    state <= S_RED;
                                end
                            end
                        endcase
                    end
                end
                // Reduce k then x_b; the second completion launches the first square of EXP.
                S_RED: begin
                    case (phase)
                        2'd0: begin
                            mm_a <= k_reg; mm_b <= W'(1); mm_r <= '0;
                            mm_cnt <= 16'(W); mm_run <= 1'b1; phase <= 2'd1;
                        end
                        2'd1: if (!mm_run) begin
                            kr   <= mm_r[W-1:0];
                            mm_a <= xb; mm_b <= W'(1); mm_r <= '0;
                            mm_cnt <= 16'(W); mm_run <= 1'b1; phase <= 2'd2;
                        end
                        default: if (!mm_run) begin
                            xr      <= mm_r[W-1:0];
                            mm_a    <= W'(1); mm_b <= W'(1); mm_r <= '0;
                            mm_cnt  <= 16'(W); mm_run <= 1'b1;
                            bit_cnt <= 16'(W);
                            phase   <= 2'd1;
                            state   <= S_EXP;
                        end
                    endcase
                end
                // phase 1: square done; phase 2: multiply by kr done. Next square chains without gaps.
                S_EXP: begin
                    if (!mm_run && phase == 2'd1 && e_reg[W-1]) begin
                        mm_a <= mm_r[W-1:0]; mm_b <= kr; mm_r <= '0;
                        mm_cnt <= 16'(W); mm_run <= 1'b1; phase <= 2'd2;
                    end else if (!mm_run && phase != 2'd0) begin
                        acc     <= mm_r[W-1:0];
                        e_reg   <= e_reg << 1;
                        bit_cnt <= bit_cnt - 16'd1;
                        if (bit_cnt == 16'd1) begin
                            phase <= 2'd0;
                            state <= S_SUM;
                        end else begin
                            mm_a <= mm_r[W-1:0]; mm_b <= mm_r[W-1:0]; mm_r <= '0;
                            mm_cnt <= 16'(W); mm_run <= 1'b1; phase <= 2'd1;
                        end
                    end
                end
                S_SUM: begin
                    tx_data  <= v_sum[7:0];
                    tx_sr    <= v_sum >> 8;
                    tx_valid <= 1'b1;
                    byte_cnt <= 8'd0;
                    state    <= S_TX_V;
                end
                S_TX_V: begin
                    if (tx_fire) begin
                        if (byte_cnt == 8'(NB - 1)) begin
                            tx_valid <= 1'b0;
                            rx_ready <= 1'b1;
                            byte_cnt <= 8'd0;
                            word_cnt <= 2'd0;
                            state    <= S_RX_MSG;
                        end else begin
                            tx_data  <= tx_sr[7:0];
                            tx_sr    <= tx_sr >> 8;
                            byte_cnt <= byte_cnt + 8'd1;
                        end
                    end
                end
                S_RX_MSG: begin
                    if (rx_fire) begin
                        sr       <= rx_word;
                        byte_cnt <= byte_cnt + 8'd1;
                    end
                    if (rx_last) begin
                        byte_cnt <= 8'd0;
                        word_cnt <= word_cnt + 2'd1;
                        if (word_cnt[0] == b_sel) mb <= rx_word;
                        if (word_cnt[0]) begin
                            rx_ready <= 1'b0;
                            phase    <= 2'd0;
                            state    <= S_UNBLIND;
                        end
                    end
                end
                S_UNBLIND: begin
                    case (phase)
                        2'd0: begin
                            mm_a <= mb; mm_b <= W'(1); mm_r <= '0;
                            mm_cnt <= 16'(W); mm_run <= 1'b1; phase <= 2'd1;
                        end
                        2'd1: if (!mm_run) begin
                            mb    <= mm_r[W-1:0];
                            phase <= 2'd2;
                        end
                        default: begin
                            result <= sub_mod(mb, kr, n_reg);
                            phase  <= 2'd0;
                            state  <= S_DONE;
                        end
                    endcase
                end
                S_DONE: begin
                    result_valid <= !error;
                    busy         <= 1'b0;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_oblivious_transfer_receiver.sv
// Randomised and directed bench for oblivious_transfer_receiver against a plain-arithmetic model.
module tb_oblivious_transfer_receiver;
    logic        clk = 1'b0, rstn = 1'b0, start = 1'b0, choice = 1'b0;
    logic [31:0] k = '0;
    logic        rx_valid = 1'b0, tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_ready, tx_valid, busy, result_valid, error;
    logic [7:0]  tx_data;
    logic [31:0] result;

    oblivious_transfer_receiver #(.W(32)) dut (
        .clk(clk), .rstn(rstn), .start(start), .choice(choice), .k(k),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .busy(busy), .result_valid(result_valid), .result(result), .error(error)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int tx_seen = 0, rv_seen = 0;
    bit [7:0]  exp_tx[$];
    bit [31:0] exp_res[$];
    bit        hold_prev = 1'b0;
    logic [7:0] prev_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic fail(input string name, input string msg);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, msg);
    endtask

    function automatic bit [31:0] powmod(input bit [31:0] base, input bit [31:0] ex, input bit [31:0] n);
        bit [63:0] r, bb;
        r  = 1;
        bb = base % n;
        while (ex != 0) begin
            if (ex[0]) r = (r * bb) % n;
            bb = (bb * bb) % n;
            ex = ex >> 1;
        end
        return r[31:0];
    endfunction

    // Compare process: every accepted tx byte and every result pulse against the model queues.
    always @(negedge clk) begin
        if (!rstn) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) check("tx_hold", tx_data, prev_data);
            hold_prev = tx_valid && !tx_ready;
            prev_data = tx_data;
            if (tx_valid && tx_ready) begin
                tx_seen++;
                if (exp_tx.size() == 0) fail("tx_unexpected", $sformatf("byte %0h with none expected", tx_data));
                else check("tx_byte", tx_data, exp_tx.pop_front());
            end
            if (result_valid) begin
                rv_seen++;
                if (exp_res.size() == 0) fail("rv_unexpected", $sformatf("result %0d with none expected", result));
                else begin
                    check("result", result, exp_res.pop_front());
                    check("error_at_rv", error, 1'b0);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input bit [7:0] d, input int gap_max);
        int to;
        bit acc;
        rx_valid = 1'b0;
        repeat ($urandom_range(0, gap_max)) cyc();
        rx_valid = 1'b1;
        rx_data  = d;
        to = 0;
        forever begin
            @(negedge clk);
            acc = rx_ready;
            cyc();
            if (acc) break;
            if (++to > 3000) begin fail("rx_timeout", "byte not accepted"); break; end
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input bit [31:0] w, input int gap_max);
        for (int i = 0; i < 4; i++) send_byte(8'(w >> (8 * i)), gap_max);
    endtask

    task automatic wait_idle();
        int to;
        to = 0;
        while (busy && to < 6000) begin cyc(); to++; end
        if (busy) fail("busy_timeout", "busy never dropped");
    endtask

    task automatic pulse_start(input bit b, input bit [31:0] kk);
        choice = b;
        k      = kk;
        start  = 1'b1;
        cyc();
        start  = 1'b0;
        choice = 1'($urandom);
        k      = $urandom;
    endtask

    task automatic session(input bit [31:0] n, e, x0, x1, kk, input bit b, input bit [31:0] m0, m1,
                           input int stall, input int gap_max, input bit poke,
                           input longint lit_v, input longint lit_res);
        bit [63:0] kr, xr, ke, v, res;
        int t0, r0, to, last, st;
        t0 = tx_seen;
        r0 = rv_seen;
        if (n >= 2) begin
            kr  = kk % n;
            xr  = (b ? x1 : x0) % n;
            ke  = powmod(kr[31:0], e, n);
            v   = (xr + ke) % n;
            res = (((b ? m1 : m0) % n) + n - kr) % n;
            if (lit_v >= 0) check("model_v", v, lit_v);
            if (lit_res >= 0) check("model_res", res, lit_res);
            for (int i = 0; i < 4; i++) exp_tx.push_back(8'(v >> (8 * i)));
            exp_res.push_back(res[31:0]);
        end
        cyc();
        pulse_start(b, kk);
        check("busy_after_start", busy, 1'b1);
        check("error_cleared", error, 1'b0);
        send_word(n, gap_max);
        if (poke) begin
            cyc();
            pulse_start(~b, ~kk);
        end
        send_word(e, gap_max);
        send_word(x0, gap_max);
        send_word(x1, gap_max);
        if (n < 2) begin
            wait_idle();
            check("error_set", error, 1'b1);
            repeat (5) cyc();
            check("err_no_tx", tx_seen - t0, 0);
            check("err_no_rv", rv_seen - r0, 0);
            check("err_busy", busy, 1'b0);
            return;
        end
        tx_ready = 1'b0;
        last = tx_seen;
        st = (stall < 0) ? $urandom_range(0, 3) : stall;
        to = 0;
        while (tx_seen - t0 < 4 && to < 9000) begin
            cyc();
            to++;
            if (tx_seen != last) begin
                last = tx_seen;
                st = (stall < 0) ? $urandom_range(0, 3) : stall;
                tx_ready = 1'b0;
            end
            if (tx_seen - t0 >= 4) break;
            if (tx_valid) begin
                if (st > 0) begin st--; tx_ready = 1'b0; end
                else tx_ready = 1'b1;
            end
        end
        tx_ready = 1'b0;
        check("tx_count", tx_seen - t0, 4);
        send_word(m0, gap_max);
        send_word(m1, gap_max);
        wait_idle();
        repeat (3) cyc();
        check("rv_pulses", rv_seen - r0, 1);
        check("result_held", result, res);
        check("error_final", error, 1'b0);
        check("busy_final", busy, 1'b0);
    endtask

    task automatic check_reset_outputs();
        @(negedge clk);
        check("rst_rx_ready", rx_ready, 1'b0);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_result_valid", result_valid, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_tx_data", tx_data, 8'd0);
        check("rst_result", result, 32'd0);
    endtask

    initial begin
        int t0, stray;
        check_reset_outputs();
        repeat (2) cyc();
        rstn = 1'b1;
        cyc();

        session(3233, 17, 100, 200, 5, 1'b1, 32'h777, 32'h3ED, -1, 0, 1'b0, 53, 1000);
        session(3233, 17, 3000, 200, 5, 1'b0, 2, 32'h3ED, -1, 0, 1'b0, 2853, 3230);
        session(3233, 0, 10, 200, 7, 1'b0, 500, 9, -1, 0, 1'b0, 11, 493);
        session(3233, 0, 10, 200, 3240, 1'b0, 500, 9, -1, 0, 1'b0, 11, 493);
        session(1, 17, 100, 200, 5, 1'b1, 0, 0, -1, 0, 1'b0, -1, -1);
        session(3233, 17, 100, 200, 5, 1'b1, 32'h777, 32'h3ED, 20, 5, 1'b0, 53, 1000);

        // Abort a session during exponentiation.
        t0 = tx_seen;
        cyc();
        pulse_start(1'b1, 5);
        send_word(3233, 0); send_word(17, 0); send_word(100, 0); send_word(200, 0);
        repeat (150) cyc();
        rstn = 1'b0;
        check_reset_outputs();
        cyc();
        rstn = 1'b1;
        tx_ready = 1'b1;
        stray = 0;
        repeat (3000) begin
            cyc();
            if (tx_valid) stray++;
        end
        tx_ready = 1'b0;
        check("abort_no_tx_valid", stray, 0);
        check("abort_no_tx", tx_seen - t0, 0);
        check("abort_idle", busy, 1'b0);
        session(3233, 17, 100, 200, 5, 1'b1, 32'h777, 32'h3ED, -1, 0, 1'b1, 53, 1000);

        for (int i = 0; i < 6; i++) begin
            bit [31:0] n;
            n = $urandom;
            if (n < 2) n = 32'hFFFF_FFFB;
            session(n, $urandom, $urandom, $urandom, $urandom, 1'($urandom), $urandom, $urandom,
                    -1, 2, 1'b0, -1, -1);
        end

        check("tx_queue_drained", exp_tx.size(), 0);
        check("res_queue_drained", exp_res.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
